// File: rtl/sr_shift_sequencer_pkg.sv
// Shared definitions for the shift-register sequencer: FSM encoding,
// the minimum legal strobe period and small elaboration-time helpers.
package sr_seq_pkg;

  // Sequencer states; the fourth encoding is unused and decodes to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  // Shortest strobe period that still leaves a non-strobe cycle between CEs.
  localparam int TICK_DIV_MIN = 2;

  // Clamp a requested strobe period into the legal range.
  function automatic int tick_div_legal(input int div);
    return (div < TICK_DIV_MIN) ? TICK_DIV_MIN : div;
  endfunction

  // Width of an index able to address every bit of a WIDTH-bit frame.
  function automatic int idx_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/sr_shift_sequencer_if.sv
// Control/status bundle between a frame requester and the sequencer,
// plus the strobes the sequencer drives into the external shift register.
interface sr_shift_sequencer_if #(
  parameter int WIDTH = 4
);
  import sr_seq_pkg::*;

  localparam int IDX_W = idx_width(WIDTH);

  // Requester side
  logic             START;
  logic [WIDTH-1:0] PATTERN;
  logic             REPEAT;
  logic             ABORT;

  // Sequencer side
  logic             BUSY;
  logic             DONE;
  logic             SR_R;
  logic             SR_CE;
  logic             SR_SLI;
  logic [IDX_W-1:0] BIT_IDX;

  // The requester drives frame commands and observes status and strobes.
  modport master (
    output START, PATTERN, REPEAT, ABORT,
    input  BUSY, DONE, SR_R, SR_CE, SR_SLI, BIT_IDX
  );

  // The sequencer consumes frame commands and produces status and strobes.
  modport slave (
    input  START, PATTERN, REPEAT, ABORT,
    output BUSY, DONE, SR_R, SR_CE, SR_SLI, BIT_IDX
  );

endinterface

// File: rtl/sr_shift_sequencer_tick_gen.sv
// Mod-TICK_DIV enable generator: replaces a divided clock with a one-cycle
// tick on the fast clock. Shared by every block that needs a slow cadence.
module sr_tick_gen #(
  parameter int TICK_DIV = 4
) (
  input  logic CLK,
  input  logic R,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_reg;
  logic             at_last;

  assign at_last = (cnt_reg == CNT_LAST);
  assign tick    = en && at_last;

  // Count enabled cycles, wrapping at TICK_DIV-1; clr parks the count at zero.
  always_ff @(posedge CLK) begin
    if (R) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= at_last ? '0 : cnt_reg + CNT_W'(1);
    end
  end

endmodule

// File: rtl/sr_shift_sequencer.sv
// Frame sequencer for an R/CE/SLI shift register running on CLK. A START
// latches a pattern, clears the register once, then presents the pattern
// MSB-first with one SR_CE strobe every TICK_DIV clocks. Every output is
// registered so the external register sees glitch-free strobes.
module sr_shift_sequencer
  import sr_seq_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int TICK_DIV = 100000000
) (
  input  logic                  CLK,
  input  logic                  R,
  sr_shift_sequencer_if.slave   bus
);

  localparam int TICK_EFF = tick_div_legal(TICK_DIV);
  localparam int IDX_W    = idx_width(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] pat_reg, pat_next;
  logic             rep_reg, rep_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;
  logic             sr_r_reg, sr_r_next;
  logic             sr_ce_reg, sr_ce_next;
  logic             sli_reg, sli_next;

  logic             tick;
  logic             tick_en;
  logic             tick_clr;
  logic [WIDTH-1:0] bit_sel;

  // The tick counter runs through CLEAR and SHIFT; it sits at zero in IDLE so
  // a new frame always sees its first strobe exactly TICK_DIV cycles later.
  assign tick_en  = (state_reg == ST_CLEAR) || (state_reg == ST_SHIFT);
  assign tick_clr = (state_reg == ST_IDLE) || bus.ABORT;

  sr_tick_gen #(
    .TICK_DIV (TICK_EFF)
  ) u_tick (
    .CLK  (CLK),
    .R    (R),
    .en   (tick_en),
    .clr  (tick_clr),
    .tick (tick)
  );

  // One-hot AND-OR selection of the bit that will be presented next cycle.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit_sel
    assign bit_sel[gi] = (idx_next == IDX_W'(gi)) && pat_next[gi];
  end

  // Serial data is only driven while shifting; it is 0 in IDLE and CLEAR.
  assign sli_next = (state_next == ST_SHIFT) && (|bit_sel);

  // Next-state and next-output logic; ABORT overrides every state.
  always_comb begin
    state_next = state_reg;
    pat_next   = pat_reg;
    rep_next   = rep_reg;
    idx_next   = idx_reg;
    busy_next  = 1'b0;
    done_next  = 1'b0;
    sr_r_next  = 1'b0;
    sr_ce_next = 1'b0;

    if (bus.ABORT) begin
      state_next = ST_IDLE;
      sr_r_next  = 1'b1;
      idx_next   = '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (bus.START) begin
            pat_next   = bus.PATTERN;
            rep_next   = bus.REPEAT;
            idx_next   = LAST_IDX;
            state_next = ST_CLEAR;
            sr_r_next  = 1'b1;
            busy_next  = 1'b1;
          end
        end

        ST_CLEAR: begin
          state_next = ST_SHIFT;
          busy_next  = 1'b1;
        end

        ST_SHIFT: begin
          busy_next  = 1'b1;
          sr_ce_next = tick;
          // Advance once the strobe for the current bit has been issued.
          if (sr_ce_reg) begin
            if (idx_reg != '0) begin
              idx_next = idx_reg - IDX_W'(1);
            end else if (rep_reg) begin
              idx_next  = LAST_IDX;
              done_next = 1'b1;
            end else begin
              state_next = ST_IDLE;
              done_next  = 1'b1;
              busy_next  = 1'b0;
            end
          end
        end

        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  // State, latched frame and registered outputs; reset leaves everything at 0.
  always_ff @(posedge CLK) begin
    if (R) begin
      state_reg <= ST_IDLE;
      pat_reg   <= '0;
      rep_reg   <= 1'b0;
      idx_reg   <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      sr_r_reg  <= 1'b0;
      sr_ce_reg <= 1'b0;
      sli_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      pat_reg   <= pat_next;
      rep_reg   <= rep_next;
      idx_reg   <= idx_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
      sr_r_reg  <= sr_r_next;
      sr_ce_reg <= sr_ce_next;
      sli_reg   <= sli_next;
    end
  end

  assign bus.BUSY    = busy_reg;
  assign bus.DONE    = done_reg;
  assign bus.SR_R    = sr_r_reg;
  assign bus.SR_CE   = sr_ce_reg;
  assign bus.SR_SLI  = sli_reg;
  assign bus.BIT_IDX = idx_reg;

endmodule
